nabp_processing_swap_control: RTL

- Responder end of the swappable-unit handshake. Serves two swappable processing units (unit 0 and unit 1); each unit runs the ready → fill → fill_done → shift sequence.
- Hands out projection-angle iterations with their shifter and mapper accumulator values. Grants fill→shift swaps so that at most one unit owns the shift datapath at a time.
- Drives the select for the shared shift/mapper output mux, and signals completion after all angles have been processed.

---
 rtl/nabp_processing_swap_control.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/nabp_processing_swap_control.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nabp_processing_swap_control : iteration/swap arbiter for two swappable units
// Revision 1.0
// ----------------------------------------------------------------------------
module nabp_processing_swap_control #(
  parameter int N_ANGLES = 180,
  parameter int ANGLE_W  = 8,
  parameter int SH_W     = 16,
  parameter int MI_W     = 16,
  parameter int MB_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               kick,
  output logic               done,
  output logic [ANGLE_W-1:0] lut_index,
  input  logic [SH_W-1:0]    lut_sh_accu_base,
  input  logic [MI_W-1:0]    lut_mp_accu_init,
  input  logic [MB_W-1:0]    lut_mp_accu_base,
  output logic [SH_W-1:0]    sw_sh_accu_base,
  output logic [MI_W-1:0]    sw_mp_accu_init,
  output logic [MB_W-1:0]    sw_mp_accu_base,
  input  logic               u0_sw_next_itr,
  input  logic               u1_sw_next_itr,
  input  logic               u0_sw_swap,
  input  logic               u1_sw_swap,
  output logic               u0_sw_next_itr_ack,
  output logic               u1_sw_next_itr_ack,
  output logic               u0_sw_swap_ack,
  output logic               u1_sw_swap_ack,
  output logic               sh_sel
);

  localparam logic [0:0] C_IDLE  = 1'b0;
  localparam logic [0:0] C_RUN   = 1'b1;
  localparam logic [1:0] U_READY = 2'd0;
  localparam logic [1:0] U_FILL  = 2'd1;
  localparam logic [1:0] U_SHIFT = 2'd2;
  localparam logic [ANGLE_W-1:0] C_LAST = ANGLE_W'(N_ANGLES);

  logic [0:0]         r_ctrl;
  logic [ANGLE_W-1:0] r_index;
  logic [1:0]         r_trk [2];
  logic               r_turn;
  logic               r_sh_sel;
  logic               r_done;

  logic [1:0] w_nx;
  logic [1:0] w_sw;
  logic [1:0] w_nq;
  logic [1:0] w_sq;
  logic [1:0] w_nack;
  logic [1:0] w_sack;
  logic       w_run;
  logic       w_more;
  logic       w_any_shift;
  logic       w_fin;

  assign w_nx        = {u1_sw_next_itr, u0_sw_next_itr};
  assign w_sw        = {u1_sw_swap, u0_sw_swap};
  assign w_run       = (r_ctrl == C_RUN);
  assign w_more      = (r_index < C_LAST);
  assign w_any_shift = (r_trk[0] == U_SHIFT) || (r_trk[1] == U_SHIFT);
  assign w_fin       = w_run && (r_index == C_LAST) &&
                       (r_trk[0] == U_READY) && (r_trk[1] == U_READY);

  always_comb begin
    w_nq = 2'b00;
    w_sq = 2'b00;
    for (int k = 0; k < 2; k++) begin
      w_nq[k] = w_run && (r_trk[k] == U_READY) && w_nx[k] && w_more;
      w_sq[k] = (r_trk[k] == U_FILL) && w_sw[k] && !w_any_shift;
    end
  end

  // Contention resolved by r_turn; only iteration grants advance it.
  assign w_nack[0] = w_nq[0] && (!w_nq[1] || !r_turn);
  assign w_nack[1] = w_nq[1] && (!w_nq[0] ||  r_turn);
  assign w_sack[0] = w_sq[0] && (!w_sq[1] || !r_turn);
  assign w_sack[1] = w_sq[1] && (!w_sq[0] ||  r_turn);

  assign u0_sw_next_itr_ack = w_nack[0];
  assign u1_sw_next_itr_ack = w_nack[1];
  assign u0_sw_swap_ack     = w_sack[0];
  assign u1_sw_swap_ack     = w_sack[1];

  // Accu buses are pure pass-through so the mapper init is valid in the ack cycle.
  assign lut_index       = r_index;
  assign sw_sh_accu_base = lut_sh_accu_base;
  assign sw_mp_accu_init = lut_mp_accu_init;
  assign sw_mp_accu_base = lut_mp_accu_base;
  assign sh_sel          = r_sh_sel;
  assign done            = r_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl   <= C_IDLE;
      r_index  <= '0;
      r_trk[0] <= U_READY;
      r_trk[1] <= U_READY;
      r_turn   <= 1'b0;
      r_sh_sel <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_fin;
      case (r_ctrl)
        C_IDLE: begin
          if (kick) begin
            r_ctrl  <= C_RUN;
            r_index <= '0;
            r_turn  <= 1'b0;
          end
        end
        default: begin
          if (w_fin) begin
            r_ctrl <= C_IDLE;
          end
        end
      endcase
      if (|w_nack) begin
        r_index <= r_index + ANGLE_W'(1);
        r_turn  <= w_nack[0];
      end
      if (w_sack[0]) begin
        r_sh_sel <= 1'b0;
      end else if (w_sack[1]) begin
        r_sh_sel <= 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
        case (r_trk[k])
          U_READY: if (w_nack[k]) r_trk[k] <= U_FILL;
          U_FILL:  if (w_sack[k]) r_trk[k] <= U_SHIFT;
          U_SHIFT: if (w_nx[k])   r_trk[k] <= U_READY;
          default: r_trk[k] <= U_READY;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
